// File: rtl/multicycle_adder.sv
// Purpose : chunk-serial adder/subtractor, CHUNK bits of A and B summed per cycle.
// Latency : start accepted at edge t -> busy for NCHUNK cycles, done pulses after edge t+NCHUNK.
// Backpres: none; start is only honoured in IDLE, and starts in RUN/DONE are dropped.
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    // Refuse to build with a chunk size that does not tile the operand.
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK:0]   w_chunk;
    logic [WIDTH-1:0] w_part_next;
    logic             w_msb_cin;

    // One chunk of the sum; bit CHUNK is the carry out of this chunk.
    assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_carry};

    // On the final RUN cycle the chunk's top bit is the result MSB, so the
    // carry into the MSB falls out of the MSB's own sum bit: c = a ^ b ^ s.
    assign w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk[CHUNK-1];

    // The partial-result register only has to hold the chunks finished so far;
    // the chunk produced in the final cycle goes straight into sum, so the
    // register is one chunk narrower than the result (and absent when NCHUNK==1).
    if (NCHUNK > 1) begin : g_multi
        logic [WIDTH-CHUNK-1:0] r_part;

        assign w_part_next = {w_chunk[CHUNK-1:0], r_part};

        // Shift each new chunk in at the top; the oldest chunk ends at bit 0.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_part <= '0;
            end else if (r_state == RUN) begin
                r_part <= w_part_next[WIDTH-1:CHUNK];
            end
        end
    end else begin : g_single
        assign w_part_next = w_chunk[CHUNK-1:0];
    end

    // Control FSM with registered busy/done and the result registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1; the caller's cin is ignored.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_chunk[CHUNK];
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_part_next;
                        r_cout  <= w_chunk[CHUNK];
                        r_ovf   <= w_msb_cin ^ w_chunk[CHUNK];
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Purpose : scoreboard bench for multicycle_adder at (8,2), (4,1) and (4,4).
// Latency : expects done exactly NCHUNK edges after the accepting edge.
// Backpres: n/a; starts issued while busy must vanish without trace.
module tb_multicycle_adder;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rst_at_edge;
    int         cyc = 0;

    logic       start_s [NI];
    logic [7:0] a_s     [NI];
    logic [7:0] b_s     [NI];
    logic       cin_s   [NI];
    logic       sub_s   [NI];
    logic       busy_s  [NI];
    logic       done_s  [NI];
    logic [7:0] sum_s   [NI];
    logic       cout_s  [NI];
    logic       ovf_s   [NI];

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_at_edge <= rst_n;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int W = (k == 0) ? 8 : 4;
        localparam int C = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
        localparam int N = W / C;

        logic [W-1:0] w_sum;

        multicycle_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clock    (clk),
            .reset_n  (rst_n),
            .start    (start_s[k]),
            .a        (a_s[k][W-1:0]),
            .b        (b_s[k][W-1:0]),
            .cin      (cin_s[k]),
            .sub      (sub_s[k]),
            .busy     (busy_s[k]),
            .done     (done_s[k]),
            .sum      (w_sum),
            .cout     (cout_s[k]),
            .overflow (ovf_s[k])
        );

        assign sum_s[k] = 8'(w_sum);

        // Monitor: pops the scoreboard on every done and polices the outputs between results.
        initial begin : mon
            exp_t       e;
            int         busy_run;
            logic [9:0] last_res;
            busy_run = 0;
            last_res = '0;
            forever begin
                @(negedge clk);
                chk($sformatf("u%0d_busy_done_exclusive", k), int'(busy_s[k] & done_s[k]), 0);
                if (!rst_at_edge) begin
                    busy_run = 0;
                end else begin
                    if (busy_s[k]) busy_run++;
                    if (done_s[k]) begin
                        chk($sformatf("u%0d_done_expected", k), int'(q.size() != 0), 1);
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            chk($sformatf("u%0d_inst", k), k, int'(e.inst));
                            chk($sformatf("u%0d_sum", k), int'(sum_s[k]), int'(e.sum));
                            chk($sformatf("u%0d_cout", k), int'(cout_s[k]), int'(e.cout));
                            chk($sformatf("u%0d_ovf", k), int'(ovf_s[k]), int'(e.ovf));
                            chk($sformatf("u%0d_latency", k), cyc - e.acc, N);
                            chk($sformatf("u%0d_busy_cycles", k), busy_run, N);
                        end
                        busy_run = 0;
                    end else begin
                        chk($sformatf("u%0d_result_hold", k),
                            int'({cout_s[k], ovf_s[k], sum_s[k]}), int'(last_res));
                    end
                end
                last_res = {cout_s[k], ovf_s[k], sum_s[k]};
            end
        end
    end

    // Reference arithmetic: full-width integer sum, signed overflow by sign rule.
    task automatic golden(input int w, input int a, input int b, input int ci, input int sb,
                          output logic [7:0] s, output logic co, output logic ov);
        int mask, bb, full, am, bm, sm;
        mask = (1 << w) - 1;
        bb   = sb ? (~b & mask) : b;
        full = a + bb + (sb ? 1 : ci);
        s    = 8'(full & mask);
        co   = 1'((full >> w) & 1);
        am   = (a >> (w - 1)) & 1;
        bm   = (bb >> (w - 1)) & 1;
        sm   = (full >> (w - 1)) & 1;
        ov   = (am == bm) && (sm != am);
    endtask

    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb,
                         input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        @(posedge clk);
        #2;
        start_s[k] = 1'b1;
        a_s[k]     = a;
        b_s[k]     = b;
        cin_s[k]   = ci;
        sub_s[k]   = sb;
        @(posedge clk);
        #1;
        e.inst = 2'(k);
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.acc  = cyc;
        q.push_back(e);
        #1;
        // Operands are don't-care after acceptance; scramble them.
        start_s[k] = 1'b0;
        a_s[k]     = 8'($urandom);
        b_s[k]     = 8'($urandom);
        cin_s[k]   = 1'($urandom);
        sub_s[k]   = 1'($urandom);
    endtask

    task automatic wait_done(input int k, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_s[k]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL u%0d_done_timeout: no done within %0d cycles, required one", k, budget);
        end
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk($sformatf("u%0d_%s_busy", k, tag), int'(busy_s[k]), 0);
        chk($sformatf("u%0d_%s_done", k, tag), int'(done_s[k]), 0);
        chk($sformatf("u%0d_%s_sum", k, tag), int'(sum_s[k]), 0);
        chk($sformatf("u%0d_%s_cout", k, tag), int'(cout_s[k]), 0);
        chk($sformatf("u%0d_%s_ovf", k, tag), int'(ovf_s[k]), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] es;
        logic       ec;
        logic       eo;

        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start_s[k] = 1'b0;
            a_s[k]     = '0;
            b_s[k]     = '0;
            cin_s[k]   = 1'b0;
            sub_s[k]   = 1'b0;
        end
        // A start held during reset must be ignored.
        start_s[0] = 1'b1;
        a_s[0]     = 8'h11;
        b_s[0]     = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) chk_zero(k, "reset");
        #1;
        start_s[0] = 1'b0;
        rst_n      = 1'b1;

        // Directed vectors at WIDTH=8, CHUNK=2.
        issue(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); wait_done(0, 10);
        issue(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1); wait_done(0, 10);
        issue(0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0); wait_done(0, 10);
        issue(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1); wait_done(0, 10);
        issue(0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0); wait_done(0, 10);

        // Second start two cycles into a run must be dropped.
        issue(0, 8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        start_s[0] = 1'b1;
        a_s[0]     = 8'h10;
        b_s[0]     = 8'h10;
        sub_s[0]   = 1'b0;
        @(posedge clk);
        #2;
        start_s[0] = 1'b0;
        wait_done(0, 10);
        repeat (8) @(posedge clk);

        // Reset in the 2nd RUN cycle, with a start that must also be ignored.
        issue(0, 8'h22, 8'h33, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        start_s[0] = 1'b1;
        a_s[0]     = 8'h01;
        b_s[0]     = 8'h01;
        @(posedge clk);
        #1;
        q.delete();
        chk_zero(0, "mid_run_reset");
        #1;
        rst_n      = 1'b1;
        start_s[0] = 1'b0;
        repeat (8) @(posedge clk);
        issue(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0); wait_done(0, 10);

        // Exhaustive 4-bit sweeps, serial (CHUNK=1) and single-cycle (CHUNK=4).
        for (int k = 1; k < NI; k++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        for (int sb = 0; sb < 2; sb++) begin
                            golden(4, a, b, ci, sb, es, ec, eo);
                            issue(k, 8'(a), 8'(b), 1'(ci), 1'(sb), es, ec, eo);
                            wait_done(k, 10);
                        end
                    end
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
